// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified memory port: core has fixed priority, DMA gets a starvation override.
// Optional build macro ARB_STATS_EN adds completion and timeout counters.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       c_cnt,
  output logic [15:0]       d_cnt,
  output logic [15:0]       tmo_cnt_total,
`endif
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);
  localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam logic       TMO_EN   = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] resp_data;
  logic              tmo_hit;

  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    resp_data = '0;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_req   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && (wait_cnt_q == MAX_W)) d_gnt = 1'b1;
        else if (c_req)                     c_gnt = 1'b1;
        else if (d_req)                     d_gnt = 1'b1;
        if (c_gnt || d_gnt) begin
          state_d   = ACCESS;
          owner_d   = d_gnt;
          we_d      = d_gnt ? d_we    : c_we;
          addr_d    = d_gnt ? d_addr  : c_addr;
          wdata_d   = d_gnt ? d_wdata : c_wdata;
          tmo_cnt_d = '0;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ready || tmo_hit) begin
          // a timed-out access completes with zeroed read data
          state_d   = RESP;
          err_d     = !mem_ready;
          resp_data = mem_ready ? mem_rdata : '0;
          if (owner_q) d_rdata_d = resp_data;
          else         c_rdata_d = resp_data;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!d_req || d_gnt)        wait_cnt_d = '0;
    else if (wait_cnt_q < MAX_W) wait_cnt_d = wait_cnt_q + 8'd1;
    else                         wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign c_done    = (state_q == RESP) && !owner_q;
  assign d_done    = (state_q == RESP) && owner_q;
  assign c_err     = c_done && err_q;
  assign d_err     = d_done && err_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] c_cnt_q, d_cnt_q, tmo_tot_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_cnt_q   <= '0;
      d_cnt_q   <= '0;
      tmo_tot_q <= '0;
    end else begin
      if (c_done && (c_cnt_q != '1))                 c_cnt_q   <= c_cnt_q + 16'd1;
      if (d_done && (d_cnt_q != '1))                 d_cnt_q   <= d_cnt_q + 16'd1;
      if ((c_err || d_err) && (tmo_tot_q != '1))     tmo_tot_q <= tmo_tot_q + 16'd1;
    end
  end

  assign c_cnt         = c_cnt_q;
  assign d_cnt         = d_cnt_q;
  assign tmo_cnt_total = tmo_tot_q;
`endif

endmodule
